// File: rtl/riscv_immpack.sv
// riscv_immpack: two-stage immediate packer in front of the instruction-memory write port.
// Packs a signed immediate into the selected instruction format, flags unencodable values, tags words with a byte address.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef SRC_IMM_I
`define SRC_IMM_I 3'b000
`define SRC_IMM_S 3'b001
`define SRC_IMM_B 3'b010
`define SRC_IMM_U 3'b011
`define SRC_IMM_J 3'b100
`endif

module riscv_immpack #(
  parameter int IMEM_AW   = 12,
  parameter int BASE_ADDR = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [`XLEN-1:0]   i_in_base,
  input  logic [`XLEN-1:0]   i_in_imm,
  input  logic [2:0]         i_in_imm_src,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [`XLEN-1:0]   o_out_instr,
  output logic [IMEM_AW-1:0] o_out_addr,
  output logic               o_out_err,
  input  logic               i_clr_addr,
  output logic [7:0]         o_err_cnt
);
  localparam logic [IMEM_AW-1:0] BASE = IMEM_AW'(BASE_ADDR);
  localparam logic [IMEM_AW-1:0] STEP = IMEM_AW'(4);

  logic               s1_valid_q, s1_valid_d;
  logic [`XLEN-1:0]   s1_base_q, s1_base_d;
  logic [`XLEN-1:0]   s1_imm_q, s1_imm_d;
  logic [2:0]         s1_src_q, s1_src_d;
  logic               s2_valid_q, s2_valid_d;
  logic [`XLEN-1:0]   s2_instr_q, s2_instr_d;
  logic               s2_err_q, s2_err_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic [7:0]         err_cnt_q, err_cnt_d;

  logic               s2_load, in_hs, out_hs;
  logic               fits_12, fits_13, fits_21;
  logic [`XLEN-1:0]   enc_instr;
  logic               enc_err;

  assign s2_load    = !s2_valid_q || i_out_ready;
  assign o_in_ready = !s1_valid_q || s2_load;
  assign in_hs      = i_in_valid && o_in_ready;
  assign out_hs     = s2_valid_q && i_out_ready;

  // A value fits an N-bit signed field when every bit above its sign bit copies it.
  assign fits_12 = (&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]);
  assign fits_13 = (&s1_imm_q[31:12]) || !(|s1_imm_q[31:12]);
  assign fits_21 = (&s1_imm_q[31:20]) || !(|s1_imm_q[31:20]);

  always_comb begin
    enc_instr = s1_base_q;
    enc_err   = 1'b0;
    case (s1_src_q)
      `SRC_IMM_I: begin
        enc_instr[31:20] = s1_imm_q[11:0];
        enc_err          = !fits_12;
      end
      `SRC_IMM_S: begin
        enc_instr[31:25] = s1_imm_q[11:5];
        enc_instr[11:7]  = s1_imm_q[4:0];
        enc_err          = !fits_12;
      end
      `SRC_IMM_B: begin
        enc_instr[31]    = s1_imm_q[12];
        enc_instr[30:25] = s1_imm_q[10:5];
        enc_instr[11:8]  = s1_imm_q[4:1];
        enc_instr[7]     = s1_imm_q[11];
        enc_err          = s1_imm_q[0] || !fits_13;
      end
      `SRC_IMM_U: begin
        enc_instr[31:12] = s1_imm_q[31:12];
        enc_err          = |s1_imm_q[11:0];
      end
      `SRC_IMM_J: begin
        enc_instr[31]    = s1_imm_q[20];
        enc_instr[30:21] = s1_imm_q[10:1];
        enc_instr[20]    = s1_imm_q[11];
        enc_instr[19:12] = s1_imm_q[19:12];
        enc_err          = s1_imm_q[0] || !fits_21;
      end
      default: enc_err = 1'b1;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_base_d  = s1_base_q;
    s1_imm_d   = s1_imm_q;
    s1_src_d   = s1_src_q;
    s2_valid_d = s2_valid_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;
    addr_d     = addr_q;
    err_cnt_d  = err_cnt_q;

    if (o_in_ready) s1_valid_d = i_in_valid;
    if (in_hs) begin
      s1_base_d = i_in_base;
      s1_imm_d  = i_in_imm;
      s1_src_d  = i_in_imm_src;
    end

    if (s2_load) s2_valid_d = s1_valid_q;
    // Payload only moves with a real word so idle outputs stay quiet.
    if (s2_load && s1_valid_q) begin
      s2_instr_d = enc_instr;
      s2_err_d   = enc_err;
    end

    if (i_clr_addr)  addr_d = BASE;
    else if (out_hs) addr_d = addr_q + STEP;

    if (out_hs && s2_err_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_base_q  <= '0;
      s1_imm_q   <= '0;
      s1_src_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
      addr_q     <= BASE;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_base_q  <= s1_base_d;
      s1_imm_q   <= s1_imm_d;
      s1_src_q   <= s1_src_d;
      s2_valid_q <= s2_valid_d;
      s2_instr_q <= s2_instr_d;
      s2_err_q   <= s2_err_d;
      addr_q     <= addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign o_out_valid = s2_valid_q;
  assign o_out_instr = s2_instr_q;
  assign o_out_err   = s2_err_q;
  assign o_out_addr  = addr_q;
  assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_riscv_immpack.sv
// Directed bench for riscv_immpack: packing vectors, back-pressure, round-trip soak and counter boundaries.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef SRC_IMM_I
`define SRC_IMM_I 3'b000
`define SRC_IMM_S 3'b001
`define SRC_IMM_B 3'b010
`define SRC_IMM_U 3'b011
`define SRC_IMM_J 3'b100
`endif

module tb_riscv_immpack;
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [31:0] i_in_base;
  logic [31:0] i_in_imm;
  logic [2:0]  i_in_imm_src;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [31:0] o_out_instr;
  logic [11:0] o_out_addr;
  logic        o_out_err;
  logic        i_clr_addr;
  logic [7:0]  o_err_cnt;

  int errors = 0;
  int checks = 0;

  riscv_immpack #(.IMEM_AW(12), .BASE_ADDR(0)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_base(i_in_base), .i_in_imm(i_in_imm), .i_in_imm_src(i_in_imm_src),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_instr(o_out_instr), .o_out_addr(o_out_addr), .o_out_err(o_out_err),
    .i_clr_addr(i_clr_addr), .o_err_cnt(o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Immediate extender of the core, used to check the round trip.
  function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] s);
    case (s)
      `SRC_IMM_I: ext = {{20{w[31]}}, w[31:20]};
      `SRC_IMM_S: ext = {{20{w[31]}}, w[31:25], w[11:7]};
      `SRC_IMM_B: ext = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      `SRC_IMM_U: ext = {w[31:12], 12'b0};
      `SRC_IMM_J: ext = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default:    ext = 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] field_mask(input logic [2:0] s);
    case (s)
      `SRC_IMM_I:            field_mask = 32'hFFF0_0000;
      `SRC_IMM_S, `SRC_IMM_B: field_mask = 32'hFE00_0F80;
      default:               field_mask = 32'hFFFF_F000;
    endcase
  endfunction

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  task automatic launch(input logic [31:0] base, input logic [31:0] imm, input logic [2:0] src);
    i_in_base = base; i_in_imm = imm; i_in_imm_src = src; i_in_valid = 1'b1;
    #1;
    for (int c = 0; c < 20 && !o_in_ready; c++) step();
    step();
    i_in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!o_out_valid && lat < 20) begin step(); lat++; end
  endtask

  task automatic pack_one(input logic [31:0] base, input logic [31:0] imm, input logic [2:0] src,
                          output logic [31:0] instr, output logic err, output logic [11:0] addr,
                          output int lat);
    i_out_ready = 1'b1;
    launch(base, imm, src);
    wait_out(lat);
    if (o_out_valid) begin
      instr = o_out_instr; err = o_out_err; addr = o_out_addr;
    end else begin
      instr = 'x; err = 1'bx; addr = 'x;
    end
    step();
  endtask

  task automatic stream(input int n, input logic [31:0] base, input logic [31:0] imm,
                        input logic [2:0] src, output int nout, output logic [11:0] last_addr);
    int nin = 0;
    nout = 0; last_addr = 'x;
    i_out_ready = 1'b1; i_in_base = base; i_in_imm = imm; i_in_imm_src = src;
    for (int c = 0; c < n + 50 && nout < n; c++) begin
      i_in_valid = (nin < n);
      #1;
      if (i_in_valid && o_in_ready) nin++;
      if (o_out_valid) begin nout++; last_addr = o_out_addr; end
      @(posedge i_clk); #1;
    end
    i_in_valid = 1'b0;
  endtask

  task automatic clear_addr();
    i_clr_addr = 1'b1; step(); i_clr_addr = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] instr; logic err; logic [11:0] addr; int lat;
    i_rst = 1'b1; i_in_valid = 1'b0; i_out_ready = 1'b1; i_clr_addr = 1'b0;
    i_in_base = '0; i_in_imm = '0; i_in_imm_src = '0;
    step(); step();
    checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", o_out_valid); end
    checks++; if (o_out_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", o_out_instr); end
    checks++; if (o_out_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", o_out_err); end
    checks++; if (o_out_addr !== 12'h000) begin errors++; $display("FAIL rst_addr: got %h want 000", o_out_addr); end
    checks++; if (o_err_cnt !== 8'd0) begin errors++; $display("FAIL rst_errcnt: got %0d want 0", o_err_cnt); end
    i_rst = 1'b0;
    step();
    checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", o_in_ready); end

    pack_one(32'h13, 32'hFFFF_F800, `SRC_IMM_I, instr, err, addr, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL i_latency: got %0d want 1", lat); end
    checks++; if (instr !== 32'h8000_0013) begin errors++; $display("FAIL i_instr: got %h want 80000013", instr); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL i_err: got %b want 0", err); end
    checks++; if (addr !== 12'h000) begin errors++; $display("FAIL i_addr0: got %h want 000", addr); end
    pack_one(32'h13, 32'h5, `SRC_IMM_I, instr, err, addr, lat);
    checks++; if (instr !== 32'h0050_0013) begin errors++; $display("FAIL i_instr2: got %h want 00500013", instr); end
    checks++; if (addr !== 12'h004) begin errors++; $display("FAIL i_addr1: got %h want 004", addr); end
  endtask

  task automatic test_b();
    logic [31:0] instr; logic err; logic [11:0] addr; int lat;
    pack_one(32'h63, 32'h0000_0FFE, `SRC_IMM_B, instr, err, addr, lat);
    checks++; if (instr !== 32'h7E00_0FE3) begin errors++; $display("FAIL b_instr: got %h want 7e000fe3", instr); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL b_err: got %b want 0", err); end
    checks++; if (addr !== 12'h008) begin errors++; $display("FAIL b_addr: got %h want 008", addr); end
    pack_one(32'h63, 32'h0000_1001, `SRC_IMM_B, instr, err, addr, lat);
    checks++; if (instr !== 32'h8000_0063) begin errors++; $display("FAIL b_bad_instr: got %h want 80000063", instr); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL b_bad_err: got %b want 1", err); end
    checks++; if (o_err_cnt !== 8'd1) begin errors++; $display("FAIL b_errcnt: got %0d want 1", o_err_cnt); end
  endtask

  task automatic test_j();
    logic [31:0] instr; logic err; logic [11:0] addr; int lat;
    pack_one(32'h6F, 32'hFFFF_FFFE, `SRC_IMM_J, instr, err, addr, lat);
    checks++; if (instr !== 32'hFFFF_F06F) begin errors++; $display("FAIL j_instr: got %h want fffff06f", instr); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL j_err: got %b want 0", err); end
    pack_one(32'h6F, 32'h0010_0000, `SRC_IMM_J, instr, err, addr, lat);
    checks++; if (instr !== 32'h8000_006F) begin errors++; $display("FAIL j_bad_instr: got %h want 8000006f", instr); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL j_bad_err: got %b want 1", err); end
    checks++; if (o_err_cnt !== 8'd2) begin errors++; $display("FAIL j_errcnt: got %0d want 2", o_err_cnt); end
  endtask

  task automatic test_us();
    logic [31:0] instr; logic err; logic [11:0] addr; int lat;
    pack_one(32'h23, 32'hFFFF_FFF5, `SRC_IMM_S, instr, err, addr, lat);
    checks++; if (instr !== 32'hFE00_0AA3) begin errors++; $display("FAIL s_instr: got %h want fe000aa3", instr); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL s_err: got %b want 0", err); end
    pack_one(32'h37, 32'h1234_5000, `SRC_IMM_U, instr, err, addr, lat);
    checks++; if (instr !== 32'h1234_5037) begin errors++; $display("FAIL u_instr: got %h want 12345037", instr); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL u_err: got %b want 0", err); end
    pack_one(32'h37, 32'h1234_5001, `SRC_IMM_U, instr, err, addr, lat);
    checks++; if (instr !== 32'h1234_5037) begin errors++; $display("FAIL u_bad_instr: got %h want 12345037", instr); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL u_bad_err: got %b want 1", err); end
    pack_one(32'h1234_5678, 32'hFFFF_FFFF, 3'b111, instr, err, addr, lat);
    checks++; if (instr !== 32'h1234_5678) begin errors++; $display("FAIL src7_instr: got %h want 12345678", instr); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL src7_err: got %b want 1", err); end
    checks++; if (addr !== 12'h024) begin errors++; $display("FAIL src7_addr: got %h want 024", addr); end
    checks++; if (o_err_cnt !== 8'd4) begin errors++; $display("FAIL us_errcnt: got %0d want 4", o_err_cnt); end
  endtask

  task automatic test_backpressure();
    logic [31:0] got_i [4];
    logic [11:0] got_a [4];
    int n = 0;
    for (int k = 0; k < 4; k++) begin got_i[k] = 'x; got_a[k] = 'x; end
    clear_addr();
    checks++; if (o_out_addr !== 12'h000) begin errors++; $display("FAIL clr_idle_addr: got %h want 000", o_out_addr); end
    i_out_ready = 1'b0;
    i_in_base = 32'h13; i_in_imm = 32'd1; i_in_imm_src = `SRC_IMM_I; i_in_valid = 1'b1;
    #1;
    checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept0: got %b want 1", o_in_ready); end
    step(); i_in_imm = 32'd2;
    checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept1: got %b want 1", o_in_ready); end
    step(); i_in_imm = 32'd3;
    for (int k = 0; k < 3; k++) begin
      checks++; if (o_in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: cycle %0d got %b want 0", k, o_in_ready); end
      checks++; if (o_out_valid !== 1'b1 || o_out_instr !== 32'h0010_0013 || o_out_addr !== 12'h000)
        begin errors++; $display("FAIL bp_hold: cycle %0d got v=%b %h @%h want v=1 00100013 @000", k, o_out_valid, o_out_instr, o_out_addr); end
      step();
    end
    i_out_ready = 1'b1;
    #1;
    fork
      begin
        for (int w = 3; w <= 4; w++) begin
          i_in_imm = w; i_in_valid = 1'b1;
          for (int c = 0; c < 20 && !o_in_ready; c++) step();
          step();
        end
        i_in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 30 && n < 4; c++) begin
          if (o_out_valid) begin got_i[n] = o_out_instr; got_a[n] = o_out_addr; n++; end
          step();
        end
      end
    join
    checks++; if (n != 4) begin errors++; $display("FAIL bp_count: got %0d want 4", n); end
    for (int k = 0; k < 4; k++) begin
      logic [31:0] want_i;
      logic [11:0] want_a;
      want_i = ((k + 1) << 20) | 32'h13;
      want_a = 12'(4 * k);
      checks++; if (got_i[k] !== want_i || got_a[k] !== want_a)
        begin errors++; $display("FAIL bp_order: word %0d got %h @%h want %h @%h", k, got_i[k], got_a[k], want_i, want_a); end
    end
    step(); step();
    checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL bp_dup: got valid %b want 0", o_out_valid); end
  endtask

  task automatic test_soak();
    logic [31:0] q_imm [$];
    logic [31:0] q_base [$];
    logic [2:0]  q_src [$];
    logic [31:0] r, imm, eimm, ebase, m;
    logic [2:0]  src, esrc;
    logic [11:0] exp_addr;
    int sent = 0, got_n = 0;
    bit in_hs;
    clear_addr();
    exp_addr = 12'h000;
    i_in_valid = 1'b0;
    for (int c = 0; c < 1500 && got_n < 40; c++) begin
      i_out_ready = ($urandom_range(0, 2) != 0);
      if (!i_in_valid && sent < 40 && $urandom_range(0, 2) != 0) begin
        r = $urandom;
        src = 3'($urandom_range(0, 4));
        case (src)
          `SRC_IMM_I, `SRC_IMM_S: imm = {{20{r[11]}}, r[11:0]};
          `SRC_IMM_B: imm = {{19{r[12]}}, r[12:1], 1'b0};
          `SRC_IMM_U: imm = {r[31:12], 12'b0};
          default:    imm = {{11{r[20]}}, r[20:1], 1'b0};
        endcase
        i_in_base = $urandom; i_in_imm = imm; i_in_imm_src = src; i_in_valid = 1'b1;
      end
      #1;
      in_hs = i_in_valid && o_in_ready;
      if (o_out_valid && i_out_ready) begin
        checks++;
        if (q_imm.size() == 0) begin
          errors++; $display("FAIL soak_extra: unexpected word %h", o_out_instr);
        end else begin
          eimm = q_imm.pop_front(); ebase = q_base.pop_front(); esrc = q_src.pop_front();
          m = field_mask(esrc);
          if (ext(o_out_instr, esrc) !== eimm || o_out_err !== 1'b0 || o_out_addr !== exp_addr ||
              (o_out_instr & ~m) !== (ebase & ~m)) begin
            errors++;
            $display("FAIL soak_word: n=%0d got %h err=%b @%h imm=%h want imm=%h base=%h err=0 @%h",
                     got_n, o_out_instr, o_out_err, o_out_addr, ext(o_out_instr, esrc), eimm, ebase, exp_addr);
          end
        end
        exp_addr += 12'd4;
        got_n++;
      end
      step();
      if (in_hs) begin
        q_imm.push_back(i_in_imm); q_base.push_back(i_in_base); q_src.push_back(i_in_imm_src);
        sent++; i_in_valid = 1'b0;
      end
    end
    checks++; if (got_n != 40) begin errors++; $display("FAIL soak_count: got %0d want 40", got_n); end
    checks++; if (o_err_cnt !== 8'd4) begin errors++; $display("FAIL soak_errcnt: got %0d want 4", o_err_cnt); end
  endtask

  task automatic test_wrap();
    int nout; logic [11:0] last;
    clear_addr();
    stream(1024, 32'h13, 32'h0, `SRC_IMM_I, nout, last);
    checks++; if (nout != 1024) begin errors++; $display("FAIL wrap_count: got %0d want 1024", nout); end
    checks++; if (last !== 12'hFFC) begin errors++; $display("FAIL wrap_last: got %h want ffc", last); end
    checks++; if (o_out_addr !== 12'h000) begin errors++; $display("FAIL wrap_addr: got %h want 000", o_out_addr); end
  endtask

  task automatic test_clr();
    logic [31:0] instr; logic err; logic [11:0] addr; int lat;
    pack_one(32'h13, 32'h1, `SRC_IMM_I, instr, err, addr, lat);
    launch(32'h13, 32'h2, `SRC_IMM_I);
    wait_out(lat);
    checks++; if (o_out_valid !== 1'b1 || o_out_addr !== 12'h004)
      begin errors++; $display("FAIL clr_pre_addr: got v=%b @%h want v=1 @004", o_out_valid, o_out_addr); end
    i_clr_addr = 1'b1;
    step();
    i_clr_addr = 1'b0;
    checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL clr_consumed: got %b want 0", o_out_valid); end
    checks++; if (o_out_addr !== 12'h000) begin errors++; $display("FAIL clr_addr: got %h want 000", o_out_addr); end
    pack_one(32'h13, 32'h3, `SRC_IMM_I, instr, err, addr, lat);
    checks++; if (addr !== 12'h000 || instr !== 32'h0030_0013)
      begin errors++; $display("FAIL clr_next: got %h @%h want 00300013 @000", instr, addr); end
  endtask

  task automatic test_rst_inflight();
    int vcnt = 0;
    i_out_ready = 1'b0;
    launch(32'h13, 32'h7, `SRC_IMM_I);
    launch(32'h13, 32'h8, `SRC_IMM_I);
    checks++; if (o_out_valid !== 1'b1) begin errors++; $display("FAIL rstf_pre_valid: got %b want 1", o_out_valid); end
    #2 i_rst = 1'b1;
    #1;
    checks++; if (o_out_valid !== 1'b0 || o_out_instr !== 32'h0)
      begin errors++; $display("FAIL rstf_async: got v=%b %h want v=0 00000000", o_out_valid, o_out_instr); end
    step();
    i_rst = 1'b0;
    i_out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (o_out_valid) vcnt++;
      step();
    end
    checks++; if (vcnt != 0) begin errors++; $display("FAIL rstf_ghost: got %0d valid cycles want 0", vcnt); end
    checks++; if (o_out_addr !== 12'h000 || o_err_cnt !== 8'd0)
      begin errors++; $display("FAIL rstf_state: got @%h cnt=%0d want @000 cnt=0", o_out_addr, o_err_cnt); end
  endtask

  task automatic test_err_sat();
    int nout; logic [11:0] last;
    stream(300, 32'h13, 32'h0, 3'b111, nout, last);
    checks++; if (nout != 300) begin errors++; $display("FAIL sat_count: got %0d want 300", nout); end
    checks++; if (o_err_cnt !== 8'd255) begin errors++; $display("FAIL sat_errcnt: got %0d want 255", o_err_cnt); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_b();
    test_j();
    test_us();
    test_backpressure();
    test_soak();
    test_wrap();
    test_clr();
    test_rst_inflight();
    test_err_sat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/riscv_immpack.md
# riscv_immpack

Pipelined immediate packer: the inverse of the core's immediate extender. It takes a base instruction word, a 32-bit signed immediate and an immediate-format code. It writes the immediate into that format's instruction bit positions, flags values that cannot be encoded, and emits the finished word with a sequential instruction-memory byte address. It sits in front of the boot-loader / self-test instruction-memory write port, with valid/ready handshakes on both sides.

## Interface

Parameters:
- IMEM_AW, 12, width of output byte address; address wraps modulo 2^IMEM_AW.
- BASE_ADDR, 0, address of first emitted word after reset or clear; must be a multiple of 4.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_in_valid  in  1  input word valid.
- o_in_ready  out  1  input accepted when i_in_valid & o_in_ready at the clock edge.
- i_in_base  in  `XLEN  base instruction; bits outside the selected immediate field pass through unchanged.
- i_in_imm  in  `XLEN  immediate value, two's complement.
- i_in_imm_src  in  3  format select, same `SRC_IMM_I/S/B/U/J codes as the immediate extender.
- o_out_valid  out  1  output word valid.
- i_out_ready  in  1  output consumed when o_out_valid & i_out_ready at the clock edge.
- o_out_instr  out  `XLEN  packed instruction.
- o_out_addr  out  IMEM_AW  byte address for o_out_instr.
- o_out_err  out  1  immediate not representable, or unknown format.
- i_clr_addr  in  1  synchronous restart of the address counter to BASE_ADDR.
- o_err_cnt  out  8  saturating count of handshaked words with o_out_err=1.

## Operation

Field placement (imm = i_in_imm, bits not listed come from i_in_base):
- I: [31:20]=imm[11:0]. Error unless imm[31:11] are all equal.
- S: [31:25]=imm[11:5], [11:7]=imm[4:0]. Same range rule as I.
- B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]. Error if imm[0]=1 or imm[31:12] are not all equal.
- U: [31:12]=imm[31:12]. Error if imm[11:0]≠0.
- J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1]. Error if imm[0]=1 or imm[31:20] are not all equal.
- Any other src code: the word is i_in_base unmodified, with err=1.
- On error the truncated fields are still packed and the word is still emitted; only the flag differs.
- Round-trip property: whenever err=0, feeding the emitted word through the immediate extender with the same src returns i_in_imm.

Pipeline:
- Stage 1 registers the inputs. Stage 2 registers the encoded word and err flag, and drives the outputs.
- Stage 2 loads when it is empty or i_out_ready=1.
- o_in_ready = !s1_valid | s2_load, which gives full throughput of 1 word/cycle with no bubbles.
- With i_out_ready=0, o_out_instr, o_out_addr and o_out_err hold stable. At most 2 words are in flight.

Address counter:
- o_out_addr is the counter register. It advances by 4 on each output handshake and wraps from 2^IMEM_AW−4 to 0.
- i_clr_addr=1 loads BASE_ADDR and wins over a simultaneous increment.
- A word handshaked in the clear cycle still carries the pre-clear address.

Error counter:
- o_err_cnt increments on each output handshake with o_out_err=1.
- It saturates at 255 and is cleared only by reset.

## Timing

- Reset (asynchronous assert, synchronous release) forces:
  - s1_valid=0, o_out_valid=0, o_out_instr=0, o_out_err=0.
  - o_out_addr=BASE_ADDR, o_err_cnt=0.
  - o_in_ready=1 from the first cycle after release.
- Latency: a word accepted at edge N appears with o_out_valid=1 after edge N+1, provided stage 2 was free.
- Reset mid-stream drops all in-flight words with no partial output.
- o_in_ready depends combinationally on i_out_ready. No other path is combinational from input to output.

## Test plan

1. Reset release, then base 0x00000013, imm 0xFFFFF800, src I -> after edge N+1: instr 0x80000013, err 0, addr 0x000. Second I word gives addr 0x004.
2. B packing: base 0x00000063, imm 0x00000FFE -> 0x7E000FE3, err 0. Imm 0x00001001 -> err 1 and o_err_cnt becomes 1.
3. J packing: base 0x0000006F, imm 0xFFFFFFFE -> 0xFFFFF06F, err 0. Imm 0x00100000 -> err 1.
4. U/S packing: base 0x37, imm 0x12345000, src U -> 0x12345037. Imm 0x12345001 -> err 1. Src 3'b111 -> base unchanged, err 1.
5. Back-pressure: stream 4 words with i_out_ready=0 for 3 cycles -> outputs stay stable, o_in_ready drops after 2 accepts. All 4 emitted in order at addrs 0x000/0x004/0x008/0x00C with no loss or duplicates. Random valid/ready soak with round-trip check through the extender.
6. Boundaries:
   - 1024 handshakes wrap addr 0xFFC -> 0x000.
   - i_clr_addr coincident with a handshake -> that word keeps its address, next word gets BASE_ADDR.
   - i_rst asserted with 2 words in flight -> o_out_valid drops immediately and nothing is emitted after release.
   - 300 error words -> o_err_cnt=255.
